viterbi_ctrl: RTL and testbench
===============================

VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 64: radix-4 trellis steps (symbols) per frame; legal range 2..1024.
REQ-002 Parameter ADDR_W, default $clog2(FRAME_LEN): survivor-memory address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  frame start request, sampled in IDLE only.
REQ-006 i_abort  input  1  synchronous abort, any state.
REQ-007 i_sym_valid  input  1  received symbol available.
REQ-008 o_sym_ready  output  1  controller accepts a symbol this cycle.
REQ-009 en_b  output  1  branch-metric unit enable (1 cycle per symbol).
REQ-010 en_a  output  1  add-compare-select enable (1 cycle per symbol).
REQ-011 o_first  output  1  high with en_a on step 0 only; ACS loads initial path metrics.
REQ-012 en_s  output  1  survivor-memory write enable.
REQ-013 o_wr_addr  output  ADDR_W  survivor write address (= current step).
REQ-014 en_t  output  1  traceback enable.
REQ-015 o_tb_addr  output  ADDR_W  traceback read address.
REQ-016 o_busy  output  1  high in every state except IDLE.
REQ-017 o_done  output  1  one-cycle frame-complete pulse.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_SYM, BM, ACS, TRACE, DONE; all outputs decode from the state and counter registers only (no input-to-output combinational path).
REQ-019 IDLE: i_start=1 -> WAIT_SYM, step counter <= 0; i_start while not in IDLE SHALL be ignored.
REQ-020 WAIT_SYM: o_sym_ready=1; i_sym_valid=1 -> BM; otherwise hold indefinitely.
REQ-021 BM: en_b=1 for exactly one cycle -> ACS.
REQ-022 ACS: en_a=1, en_s=1, o_wr_addr=step, o_first=(step==0); if step==FRAME_LEN-1 -> TRACE with o_tb_addr<=FRAME_LEN-1, else step<=step+1 -> WAIT_SYM.
REQ-023 Per-symbol latency SHALL be 3 cycles minimum (accept, BM, ACS); back-to-back valid symbols give one accepted symbol every 3 cycles.
REQ-024 TRACE: en_t=1, o_tb_addr decrements by 1 per cycle; at o_tb_addr==0 -> DONE; TRACE lasts exactly FRAME_LEN cycles.
REQ-025 DONE: o_done=1 for one cycle -> IDLE.
REQ-026 Step counter SHALL never wrap; o_wr_addr and o_tb_addr SHALL stay within 0..FRAME_LEN-1.
REQ-027 i_abort=1 in any state SHALL force IDLE next cycle with all enables, o_done and o_busy low; i_abort has priority over i_start; no o_done is produced for the aborted frame.
REQ-028 Enables outside their states (en_b, en_a, en_s, en_t, o_first, o_sym_ready) SHALL be 0; at most one of en_b, en_a, en_t is high in any cycle.

Reset
REQ-029 rst=1 SHALL set state IDLE, step 0, o_tb_addr 0, and every output 0 on the next rising edge; rst has priority over i_abort and i_start.
REQ-030 rst asserted mid-frame SHALL discard the frame; the first post-reset frame behaves exactly as after power-up.

Structure
REQ-031 Shared package viterbi_pkg SHALL hold the state enum typedef, FRAME_LEN default and ADDR_W derivation, reused by ACS, survivor-memory and traceback blocks.
REQ-032 Single module, no sub-module; state register and one up/down address counter inline.

Verification (FRAME_LEN=4, i_sym_valid held 1)
REQ-033 i_start at cycle 0 -> o_sym_ready cycles 1,4,7,10; en_a cycles 3,6,9,12 with o_wr_addr 0..3; o_first only cycle 3; en_t cycles 13-16 with o_tb_addr 3,2,1,0; o_done cycle 17; o_busy low from cycle 18.
REQ-034 i_sym_valid low for 5 cycles in WAIT_SYM at step 2 -> FSM holds, no en_b/en_a; resumes on valid, o_done delayed by exactly 5 cycles.
REQ-035 i_abort during TRACE at o_tb_addr=2 -> IDLE next cycle, en_t=0, no o_done; new i_start runs a full frame from step 0.
REQ-036 rst during ACS of step 1 -> all outputs 0 next cycle, state IDLE; i_start and i_abort asserted together with rst have no effect.
REQ-037 i_start pulsed during WAIT_SYM and TRACE -> ignored; exactly one o_done per frame.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: FSM state type and frame geometry shared by the Viterbi controller, ACS, survivor-memory and traceback blocks
package viterbi_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_SYM, BM, ACS, TRACE, DONE} state_t;
    localparam int FRAME_LEN_DEF = 64;
    function automatic int addr_w(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction
endpackage

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: radix-4 Viterbi frame sequencer; clk/rst, i_start/i_abort/i_sym_valid in, o_sym_ready, en_b/en_a/en_s/en_t strobes, o_first, o_wr_addr/o_tb_addr, o_busy/o_done out
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ADDR_W = addr_w(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_sym_valid,
    output logic              o_sym_ready,
    output logic              en_b,
    output logic              en_a,
    output logic              o_first,
    output logic              en_s,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              en_t,
    output logic [ADDR_W-1:0] o_tb_addr,
    output logic              o_busy,
    output logic              o_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    // One counter serves both phases: it counts steps up during ACS and, since the
    // last step already equals FRAME_LEN-1, counts straight back down during traceback.
    assign o_wr_addr = r_addr;
    assign o_tb_addr = r_addr;
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        if (i_abort) begin
            w_state = IDLE;
            w_addr  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state = i_start ? WAIT_SYM : IDLE;
                    w_addr  = '0;
                end
                WAIT_SYM: w_state = i_sym_valid ? BM : WAIT_SYM;
                BM:       w_state = ACS;
                ACS: begin
                    w_state = (r_addr == LAST) ? TRACE : WAIT_SYM;
                    w_addr  = (r_addr == LAST) ? r_addr : r_addr + ONE;
                end
                TRACE: begin
                    w_state = (r_addr == '0) ? DONE : TRACE;
                    w_addr  = (r_addr == '0) ? r_addr : r_addr - ONE;
                end
                DONE:     w_state = IDLE;
                default:  w_state = IDLE;
            endcase
        end
    end
    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            o_sym_ready <= 1'b0;
            en_b        <= 1'b0;
            en_a        <= 1'b0;
            en_s        <= 1'b0;
            o_first     <= 1'b0;
            en_t        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            o_sym_ready <= w_state == WAIT_SYM;
            en_b        <= w_state == BM;
            en_a        <= w_state == ACS;
            en_s        <= w_state == ACS;
            o_first     <= (w_state == ACS) && (w_addr == '0);
            en_t        <= w_state == TRACE;
            o_busy      <= w_state != IDLE;
            o_done      <= w_state == DONE;
        end
    end
endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: schedule-model checks of viterbi_ctrl with FRAME_LEN=4
module tb_viterbi_ctrl;
    localparam int FL = 4;
    localparam int MAXC = 200;
    logic clk = 1'b0;
    logic rst, i_start, i_abort, i_sym_valid;
    logic o_sym_ready, en_b, en_a, o_first, en_s, en_t, o_busy, o_done;
    logic [1:0] o_wr_addr, o_tb_addr;
    logic [11:0] obs;
    logic st [MAXC];
    logic vl [MAXC];
    logic ab [MAXC];
    logic [11:0] ev [MAXC];
    logic [11:0] em [MAXC];
    int errors = 0;
    int checks = 0;

    viterbi_ctrl #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_sym_valid(i_sym_valid),
        .o_sym_ready(o_sym_ready), .en_b(en_b), .en_a(en_a), .o_first(o_first), .en_s(en_s),
        .o_wr_addr(o_wr_addr), .en_t(en_t), .o_tb_addr(o_tb_addr), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    assign obs = {o_sym_ready, en_b, en_a, o_first, en_s, en_t, o_busy, o_done, o_wr_addr, o_tb_addr};

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            st[i] = 1'b0;
            vl[i] = 1'b0;
            ab[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_sym_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic void put(input int t, input int lim, input int b);
        if (t <= lim) ev[t][b] = 1'b1;
    endfunction

    // Expected timeline: a frame accepts symbol k at the first valid cycle no earlier
    // than 3 cycles after the previous acceptance, then BM, ACS; FL trace cycles follow
    // the last ACS, then DONE. An abort blanks everything after the abort cycle.
    task automatic build(input int n);
        int acc [FL];
        int t, d, x, lim, c;
        for (int i = 0; i < MAXC; i++) begin
            ev[i] = '0;
            em[i] = 12'hFF0;
        end
        c = 0;
        while (c < n) begin
            if (ab[c] || !st[c]) c++;
            else begin
                t = c + 1;
                for (int k = 0; k < FL; k++) begin
                    while (t < n && !vl[t]) t++;
                    acc[k] = t;
                    t += 3;
                end
                d = acc[FL-1] + 3 + FL;
                x = MAXC;
                for (int i = c + 1; i <= d && i < n; i++) if (ab[i] && x == MAXC) x = i;
                lim = (x < n) ? x : n - 1;
                for (int i = c + 1; i <= d; i++) put(i, lim, 5);
                for (int k = 0; k < FL; k++) begin
                    for (int i = (k == 0) ? c + 1 : acc[k-1] + 3; i <= acc[k]; i++) put(i, lim, 11);
                    put(acc[k] + 1, lim, 10);
                    put(acc[k] + 2, lim, 9);
                    put(acc[k] + 2, lim, 7);
                    if (k == 0) put(acc[k] + 2, lim, 8);
                    if (acc[k] + 2 <= lim) begin
                        ev[acc[k]+2][3:2] = 2'(k);
                        em[acc[k]+2][3:2] = 2'b11;
                    end
                end
                for (int j = 0; j < FL; j++) begin
                    t = acc[FL-1] + 3 + j;
                    put(t, lim, 6);
                    if (t <= lim) begin
                        ev[t][1:0] = 2'(FL - 1 - j);
                        em[t][1:0] = 2'b11;
                    end
                end
                put(d, lim, 4);
                c = ((x <= d) ? x : d) + 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b1;
        i_abort = 1'b0;
        i_sym_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 12'h000) begin errors++; $display("FAIL reset_state got %h expected 000", obs); end
        rst = 1'b0;
        i_start = 1'b0;
        i_sym_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 12'h000) begin errors++; $display("FAIL reset_idle got %h expected 000", obs); end
    endtask

    task automatic test_nominal();
        int dc = -1;
        clear_stim();
        st[0] = 1'b1;
        for (int i = 0; i < MAXC; i++) vl[i] = 1'b1;
        build(22);
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ((obs & em[i]) !== ev[i]) begin errors++; $display("FAIL nominal cycle %0d got %h expected %h", i, obs & em[i], ev[i]); end
            if (o_done) dc = i;
            i_start = st[i]; i_sym_valid = vl[i]; i_abort = ab[i];
        end
        checks++;
        if (dc !== 17) begin errors++; $display("FAIL nominal_done_cycle got %0d expected 17", dc); end
    endtask

    task automatic test_stall();
        int dc = -1;
        clear_stim();
        st[0] = 1'b1;
        for (int i = 0; i < MAXC; i++) vl[i] = (i < 7 || i > 11);
        build(27);
        do_reset();
        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ((obs & em[i]) !== ev[i]) begin errors++; $display("FAIL stall cycle %0d got %h expected %h", i, obs & em[i], ev[i]); end
            if (o_done) dc = i;
            i_start = st[i]; i_sym_valid = vl[i]; i_abort = ab[i];
        end
        checks++;
        if (dc !== 22) begin errors++; $display("FAIL stall_done_cycle got %0d expected 22", dc); end
    endtask

    task automatic test_abort();
        int nd = 0;
        int dc = -1;
        clear_stim();
        st[0] = 1'b1;
        ab[14] = 1'b1;
        st[16] = 1'b1;
        for (int i = 0; i < MAXC; i++) vl[i] = 1'b1;
        build(37);
        do_reset();
        for (int i = 0; i < 37; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ((obs & em[i]) !== ev[i]) begin errors++; $display("FAIL abort cycle %0d got %h expected %h", i, obs & em[i], ev[i]); end
            if (i == 15) begin
                checks++;
                if (obs !== 12'h000 && (obs & 12'hFF0) !== 12'h000) begin errors++; $display("FAIL abort_idle got %h expected 000", obs); end
            end
            if (o_done) begin nd++; dc = i; end
            i_start = st[i]; i_sym_valid = vl[i]; i_abort = ab[i];
        end
        checks++;
        if (nd !== 1 || dc !== 33) begin errors++; $display("FAIL abort_done got %0d pulses at %0d expected 1 at 33", nd, dc); end
    endtask

    task automatic test_start_ignored();
        int nd = 0;
        clear_stim();
        st[0] = 1'b1;
        st[4] = 1'b1;
        st[14] = 1'b1;
        for (int i = 0; i < MAXC; i++) vl[i] = 1'b1;
        build(24);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ((obs & em[i]) !== ev[i]) begin errors++; $display("FAIL start_ignored cycle %0d got %h expected %h", i, obs & em[i], ev[i]); end
            if (o_done) nd++;
            i_start = st[i]; i_sym_valid = vl[i]; i_abort = ab[i];
        end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL start_ignored_done_count got %0d expected 1", nd); end
    endtask

    task automatic test_rst_mid();
        int dc = -1;
        do_reset();
        i_start = 1'b1;
        i_sym_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
        checks++;
        if ((obs & 12'hFFC) !== 12'h2A4) begin errors++; $display("FAIL rst_mid_acs1 got %h expected %h", obs & 12'hFFC, 12'h2A4); end
        rst = 1'b1;
        i_start = 1'b1;
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 12'h000) begin errors++; $display("FAIL rst_mid_outputs got %h expected 000", obs); end
        rst = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 12'h000) begin errors++; $display("FAIL rst_mid_idle got %h expected 000", obs); end
        clear_stim();
        st[0] = 1'b1;
        for (int i = 0; i < MAXC; i++) vl[i] = 1'b1;
        build(20);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ((obs & em[i]) !== ev[i]) begin errors++; $display("FAIL rst_mid_frame cycle %0d got %h expected %h", i, obs & em[i], ev[i]); end
            if (o_done) dc = i;
            i_start = st[i]; i_sym_valid = vl[i]; i_abort = ab[i];
        end
        checks++;
        if (dc !== 17) begin errors++; $display("FAIL rst_mid_done_cycle got %0d expected 17", dc); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            clear_stim();
            for (int i = 0; i < 150; i++) begin
                st[i] = ($urandom_range(0, 9) < 3);
                vl[i] = ($urandom_range(0, 9) < 7);
                ab[i] = ($urandom_range(0, 59) == 0);
            end
            build(150);
            do_reset();
            for (int i = 0; i < 150; i++) begin
                @(posedge clk);
                #1;
                checks++;
                if ((obs & em[i]) !== ev[i]) begin errors++; $display("FAIL random run %0d cycle %0d got %h expected %h", r, i, obs & em[i], ev[i]); end
                i_start = st[i]; i_sym_valid = vl[i]; i_abort = ab[i];
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_abort();
        test_start_ignored();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
